// File: rtl/stream_block_buffer_pkg.sv
// Shared types and helpers for the stream block buffer: FSM state encoding,
// a clog2 that never returns zero, and the statistics counter width.
package stream_block_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int STALL_CNT_W = 32;

  // Counter widths must be at least one bit even when the range is a single value.
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_block_buffer_if.sv
// AXI-Stream style beat bus. Handshake: a beat transfers on a rising edge where
// tvalid && tready; once tvalid is raised, tvalid/tdata/tlast hold until that transfer.
interface stream_block_buffer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered storage; the head entry is visible on o_rdata
// whenever o_empty is low, so a push shows up on the read side one cycle later.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/stream_block_buffer.sv
// Elastic PE-lane stream stage: FIFO plus block/stream position tracking, tlast per
// block and a done pulse per stream. STREAM_BLOCK_BUFFER_STATS_EN adds a stall counter.
module stream_block_buffer
  import stream_block_buffer_pkg::*;
#(
  parameter int ELEM_WIDTH         = 8,
  parameter int PE                 = 4,
  parameter int s_axis_input_BDIM  = 16,
  parameter int s_axis_input_SDIM  = 4,
  parameter int m_axis_output_BDIM = 16,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  stream_block_buffer_if.slave   s_axis_input,
  stream_block_buffer_if.master  m_axis_output,
  output logic                   done,
  output logic                   busy
`ifdef STREAM_BLOCK_BUFFER_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);
  localparam int DW     = PE * ELEM_WIDTH;
  localparam int BEATS  = s_axis_input_BDIM / PE;
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int BLK_W  = clog2_min1(s_axis_input_SDIM);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(s_axis_input_SDIM - 1);

  if (m_axis_output_BDIM != s_axis_input_BDIM) begin : g_bdim_check
    $error("stream_block_buffer: m_axis_output_BDIM must equal s_axis_input_BDIM");
  end
  if ((s_axis_input_BDIM % PE) != 0) begin : g_pe_check
    $error("stream_block_buffer: s_axis_input_BDIM must be divisible by PE");
  end
  if (s_axis_input_SDIM < 1) begin : g_sdim_check
    $error("stream_block_buffer: s_axis_input_SDIM must be at least 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BLK_W-1:0]  r_blk_cnt;
  logic [DW-1:0]     w_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_last_beat;
  logic              w_final;

  stream_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .i_wdata (s_axis_input.tdata),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Ready depends only on registered occupancy, never on the downstream ready.
  assign s_axis_input.tready  = !w_full && !ap_rst;
  assign w_valid              = !w_empty;
  assign w_push               = s_axis_input.tvalid && s_axis_input.tready;
  assign w_pop                = w_valid && m_axis_output.tready;
  assign w_last_beat          = (r_beat_cnt == LAST_BEAT);
  assign w_final              = w_pop && w_last_beat && (r_blk_cnt == LAST_BLK);

  assign m_axis_output.tvalid = w_valid;
  assign m_axis_output.tdata  = w_valid ? w_rdata : '0;
  assign m_axis_output.tlast  = w_valid && w_last_beat;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_beat_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_pop) begin
      if (w_last_beat) begin
        r_beat_cnt <= '0;
        r_blk_cnt  <= (r_blk_cnt == LAST_BLK) ? '0 : r_blk_cnt + BLK_W'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stream completion wins from any state so queued next-stream beats never hide a done.
  always_comb begin
    w_state_nxt = r_state;
    if (w_final) begin
      w_state_nxt = DONE;
    end else begin
      case (r_state)
        IDLE:    if (w_push) w_state_nxt = ACTIVE;
        ACTIVE:  w_state_nxt = ACTIVE;
        DONE:    w_state_nxt = w_push ? ACTIVE : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign done = (r_state == DONE);
  assign busy = (r_state == ACTIVE);

`ifdef STREAM_BLOCK_BUFFER_STATS_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || (r_state == DONE)) begin
      r_stall_cnt <= '0;
    end else if (w_valid && !m_axis_output.tready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stream_block_buffer.sv
// Bench for stream_block_buffer: queue-based reference model plus directed and
// random scenarios; STREAM_BLOCK_BUFFER_STATS_EN also exercises the stall counter.
module tb_stream_block_buffer;
  localparam int ELEM_WIDTH = 8;
  localparam int PE         = 4;
  localparam int BDIM       = 16;
  localparam int SDIM       = 4;
  localparam int DEPTH      = 8;
  localparam int DW         = PE * ELEM_WIDTH;
  localparam int BEATS      = BDIM / PE;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic done;
  logic busy;
`ifdef STREAM_BLOCK_BUFFER_STATS_EN
  logic [31:0] stall_cnt;
`endif

  stream_block_buffer_if #(.WIDTH(DW)) in_if ();
  stream_block_buffer_if #(.WIDTH(DW)) out_if ();

  stream_block_buffer #(
    .ELEM_WIDTH         (ELEM_WIDTH),
    .PE                 (PE),
    .s_axis_input_BDIM  (BDIM),
    .s_axis_input_SDIM  (SDIM),
    .m_axis_output_BDIM (BDIM),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_axis_input  (in_if),
    .m_axis_output (out_if),
    .done          (done),
    .busy          (busy)
`ifdef STREAM_BLOCK_BUFFER_STATS_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            n_vec     = 0;
  int            n_miss    = 0;
  int            out_beats = 0;
  int            tot_out   = 0;
  int            tot_tlast = 0;
  int            tot_done  = 0;
  bit            exp_done  = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(negedge ap_clk) begin
    logic [DW-1:0] exp_d;
    logic          exp_last;
    bit            exp_valid;
    bit            exp_ready;
    if (ap_rst) begin
      exp_q.delete();
      out_beats  = 0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      exp_valid = (exp_q.size() != 0);
      exp_ready = (exp_q.size() < DEPTH);
      n_vec++;
      if (out_if.tvalid !== exp_valid) begin
        n_miss++;
        $display("FAIL m_tvalid: got %b expected %b", out_if.tvalid, exp_valid);
      end
      n_vec++;
      if (in_if.tready !== exp_ready) begin
        n_miss++;
        $display("FAIL s_tready: got %b expected %b", in_if.tready, exp_ready);
      end
      n_vec++;
      if (done !== exp_done) begin
        n_miss++;
        $display("FAIL done_timing: got %b expected %b", done, exp_done);
      end
      if (done === 1'b1) tot_done++;
      exp_done = 1'b0;
      if (prev_stall) begin
        n_vec++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== prev_data || out_if.tlast !== prev_last) begin
          n_miss++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   out_if.tvalid, out_if.tdata, out_if.tlast, prev_data, prev_last);
        end
      end
      if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL out_data: got %h expected no beat", out_if.tdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_if.tdata !== exp_d) begin
            n_miss++;
            $display("FAIL out_data: got %h expected %h", out_if.tdata, exp_d);
          end
        end
        exp_last = ((out_beats % BEATS) == BEATS - 1);
        n_vec++;
        if (out_if.tlast !== exp_last) begin
          n_miss++;
          $display("FAIL tlast: beat %0d got %b expected %b", out_beats, out_if.tlast, exp_last);
        end
        if (out_if.tlast === 1'b1) tot_tlast++;
        out_beats++;
        tot_out++;
        if ((out_beats % (BEATS * SDIM)) == 0) exp_done = 1'b1;
      end
      if (in_if.tvalid === 1'b1 && in_if.tready === 1'b1) exp_q.push_back(in_if.tdata);
      prev_stall = (out_if.tvalid === 1'b1) && (out_if.tready !== 1'b1);
      prev_data  = out_if.tdata;
      prev_last  = out_if.tlast;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    ap_rst       = 1'b1;
    in_if.tvalid = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int bound, output bit ok);
    int c = 0;
    ok = 1'b0;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    while (!ok && c < bound) begin
      @(negedge ap_clk);
      if (in_if.tready === 1'b1) ok = 1'b1;
      @(posedge ap_clk); #1;
      c++;
    end
    in_if.tvalid = 1'b0;
  endtask

  function automatic logic [DW-1:0] lane_pattern(input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < PE; i++) d[i*ELEM_WIDTH +: ELEM_WIDTH] = ELEM_WIDTH'(b * PE + i);
    return d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ap_rst        = 1'b1;
    in_if.tvalid  = 1'b1;
    in_if.tdata   = 32'hA5A5_0001;
    out_if.tready = 1'b0;
    @(posedge ap_clk); #1;
    repeat (3) begin
      @(negedge ap_clk);
      n_vec++;
      if ({in_if.tready, out_if.tvalid, out_if.tlast, done, busy} !== 5'b0) begin
        n_miss++;
        $display("FAIL reset_outputs: got rdy/val/last/done/busy=%b expected 00000",
                 {in_if.tready, out_if.tvalid, out_if.tlast, done, busy});
      end
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    @(posedge ap_clk); #1;
    in_if.tvalid = 1'b0;
    @(negedge ap_clk);
    n_vec++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== 32'hA5A5_0001 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL first_latency: got v=%b d=%h busy=%b expected v=1 d=a5a50001 busy=1",
               out_if.tvalid, out_if.tdata, busy);
    end
    @(posedge ap_clk); #1;
    pulse_reset();
  endtask

  task automatic test_full_stream();
    bit ok;
    bit seen = 1'b0;
    logic prev_busy = 1'b0;
    int t0 = tot_tlast;
    int d0 = tot_done;
    out_if.tready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      send_beat(lane_pattern(b), 20, ok);
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL full_send: beat %0d got not accepted expected accepted", b);
      end
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ap_clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
          n_miss++;
          $display("FAIL busy_fall: got busy=%b prev=%b expected busy=0 prev=1", busy, prev_busy);
        end
      end
      prev_busy = busy;
      @(posedge ap_clk); #1;
    end
    n_vec++;
    if (!seen || (tot_tlast - t0) != 4 || (tot_done - d0) != 1) begin
      n_miss++;
      $display("FAIL full_stream: got seen=%0d tlasts=%0d dones=%0d expected 1/4/1",
               seen, tot_tlast - t0, tot_done - d0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int idx = 0;
    int cyc = 0;
    bit a;
    out_if.tready = 1'b0;
    in_if.tvalid  = 1'b1;
    in_if.tdata   = 32'hB000_0000;
    repeat (12) begin
      @(negedge ap_clk);
      a = (in_if.tvalid === 1'b1 && in_if.tready === 1'b1);
      @(posedge ap_clk); #1;
      if (a) begin
        acc++;
        idx++;
        in_if.tdata = 32'hB000_0000 + DW'(idx);
      end
    end
    n_vec++;
    if (acc != 8) begin
      n_miss++;
      $display("FAIL bp_accept: got %0d expected 8", acc);
    end
    @(negedge ap_clk);
    n_vec++;
    if (in_if.tready !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_full_ready: got %b expected 0", in_if.tready);
    end
    @(posedge ap_clk); #1;
    out_if.tready = 1'b1;
    while ((idx < 10 || exp_q.size() != 0) && cyc < 100) begin
      @(negedge ap_clk);
      a = (in_if.tvalid === 1'b1 && in_if.tready === 1'b1);
      @(posedge ap_clk); #1;
      if (a) begin
        acc++;
        idx++;
        in_if.tdata = 32'hB000_0000 + DW'(idx);
        if (idx >= 10) in_if.tvalid = 1'b0;
      end
      cyc++;
    end
    n_vec++;
    if (acc != 10 || cyc >= 100) begin
      n_miss++;
      $display("FAIL bp_drain: got accepted=%0d cycles=%0d expected 10 within 100", acc, cyc);
    end
    pulse_reset();
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc  = 0;
    int t0   = tot_tlast;
    int d0   = tot_done;
    bit a;
    in_if.tvalid = 1'b0;
    while ((sent < 48 || exp_q.size() != 0) && cyc < 2000) begin
      if (in_if.tvalid !== 1'b1 && sent < 48 && $urandom_range(1) == 1) begin
        in_if.tvalid = 1'b1;
        in_if.tdata  = DW'($urandom());
      end
      out_if.tready = ($urandom_range(1) == 1);
      @(negedge ap_clk);
      a = (in_if.tvalid === 1'b1 && in_if.tready === 1'b1);
      @(posedge ap_clk); #1;
      if (a) begin
        sent++;
        in_if.tvalid = 1'b0;
      end
      cyc++;
    end
    out_if.tready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    n_vec++;
    if (cyc >= 2000 || (tot_tlast - t0) != 12 || (tot_done - d0) != 3) begin
      n_miss++;
      $display("FAIL random_streams: got cycles=%0d tlasts=%0d dones=%0d expected <2000/12/3",
               cyc, tot_tlast - t0, tot_done - d0);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int o0 = tot_out;
    int t0;
    int d0;
    out_if.tready = 1'b1;
    for (int i = 0; i < 40 && (tot_out - o0) < 6; i++) send_beat(DW'($urandom()), 20, ok);
    pulse_reset();
    @(negedge ap_clk);
    n_vec++;
    if ({out_if.tvalid, out_if.tlast, done, busy, in_if.tready} !== 5'b00001) begin
      n_miss++;
      $display("FAIL mid_reset_state: got val/last/done/busy/rdy=%b expected 00001",
               {out_if.tvalid, out_if.tlast, done, busy, in_if.tready});
    end
    @(posedge ap_clk); #1;
    t0 = tot_tlast;
    d0 = tot_done;
    for (int b = 0; b < 16; b++) send_beat(lane_pattern(b + 100), 20, ok);
    repeat (4) @(posedge ap_clk);
    #1;
    n_vec++;
    if ((tot_tlast - t0) != 4 || (tot_done - d0) != 1) begin
      n_miss++;
      $display("FAIL mid_reset_stream: got tlasts=%0d dones=%0d expected 4/1",
               tot_tlast - t0, tot_done - d0);
    end
  endtask

`ifdef STREAM_BLOCK_BUFFER_STATS_EN
  task automatic test_stats();
    bit ok;
    bit seen = 1'b0;
    pulse_reset();
    out_if.tready = 1'b0;
    send_beat(lane_pattern(200), 4, ok);
    repeat (5) @(posedge ap_clk);
    #1;
    n_vec++;
    if (stall_cnt !== 32'd5) begin
      n_miss++;
      $display("FAIL stall_count: got %0d expected 5", stall_cnt);
    end
    out_if.tready = 1'b1;
    for (int b = 1; b < 16; b++) send_beat(lane_pattern(200 + b), 20, ok);
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge ap_clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (stall_cnt !== 32'd5) begin
          n_miss++;
          $display("FAIL stall_at_done: got %0d expected 5", stall_cnt);
        end
      end
      @(posedge ap_clk); #1;
    end
    @(negedge ap_clk);
    n_vec++;
    if (!seen || stall_cnt !== 32'd0) begin
      n_miss++;
      $display("FAIL stall_clear: got seen=%0d cnt=%0d expected 1/0", seen, stall_cnt);
    end
    @(posedge ap_clk); #1;
  endtask
`endif

  initial begin
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b0;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_random();
    test_mid_reset();
`ifdef STREAM_BLOCK_BUFFER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
